// File: rtl/multiplier_control_if.sv
// Handshake and strobe bundle between the multiplier sequencer and its requester, datapath and counter.
interface multiplier_control_if;
  logic start_valid;
  logic start_ready;
  logic do_load;
  logic do_add;
  logic do_shift;
  logic multiplier_lsb;
  logic do_preset;
  logic do_decrement;
  logic is_zero;
  logic result_valid;
  logic result_ready;
  logic protocol_error;

  modport master (
    input  start_valid, multiplier_lsb, is_zero, result_ready,
    output start_ready, do_load, do_add, do_shift, do_preset, do_decrement,
           result_valid, protocol_error
  );

  modport slave (
    output start_valid, multiplier_lsb, is_zero, result_ready,
    input  start_ready, do_load, do_add, do_shift, do_preset, do_decrement,
           result_valid, protocol_error
  );
endinterface

// File: rtl/multiplier_control.sv
// Shift-add multiplier sequencer: start accepted in IDLE, 1 LOAD + N STEP cycles, result_valid N+2 cycles after accept.
// Backpressure: start is only taken in IDLE; DONE holds result_valid and all outputs stable until result_ready.
module multiplier_control #(
  parameter int N = 4
) (
  input  logic              clock,
  input  logic              reset,
  multiplier_control_if.master bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] step_nxt;
  logic          err;
  logic          err_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      step_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    step_nxt           = step_cnt;
    err_nxt            = err;
    bus.start_ready    = 1'b0;
    bus.do_load        = 1'b0;
    bus.do_add         = 1'b0;
    bus.do_shift       = 1'b0;
    bus.do_preset      = 1'b0;
    bus.do_decrement   = 1'b0;
    bus.result_valid   = 1'b0;
    bus.protocol_error = 1'b0;

    case (state)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) state_nxt = LOAD;
      end
      LOAD: begin
        bus.do_load   = 1'b1;
        bus.do_preset = 1'b1;
        step_nxt      = '0;
        err_nxt       = 1'b0;
        state_nxt     = STEP;
      end
      STEP: begin
        bus.do_shift = 1'b1;
        bus.do_add   = bus.multiplier_lsb;
        if (bus.is_zero) begin
          state_nxt = DONE;
        end else begin
          bus.do_decrement = 1'b1;
          step_nxt         = step_cnt + ONE;
          // Counter never reached zero within N steps: give up and flag it.
          if (step_cnt == LAST) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        bus.result_valid   = 1'b1;
        bus.protocol_error = err;
        if (bus.result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control with a behavioural counter/datapath and a transaction-level output model.
module tb_multiplier_control;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multiplier_control_if bus();
  multiplier_control #(.N(N)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic [N-1:0]         mplier_in = '0;
  bit                   wd = 1'b0;
  logic [$clog2(N)-1:0] cnt;
  logic [N-1:0]         mreg;
  int                   n_checks = 0;
  int                   n_fail = 0;
  int                   cyc = 0;

  // Counter and multiplier register driven by the DUT's strobes; wd models a missing counter.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.do_preset) cnt <= ($clog2(N))'(N - 1);
    else if (bus.do_decrement) cnt <= cnt - 1'b1;
    if (bus.do_load) mreg <= mplier_in;
    else if (bus.do_shift) mreg <= mreg >> 1;
  end
  assign bus.is_zero        = wd ? 1'b0 : (cnt == '0);
  assign bus.multiplier_lsb = mreg[0];

  // {start_ready, do_load, do_add, do_shift, do_preset, do_decrement, result_valid, protocol_error}
  function automatic logic [7:0] outs();
    return {bus.start_ready, bus.do_load, bus.do_add, bus.do_shift,
            bus.do_preset, bus.do_decrement, bus.result_valid, bus.protocol_error};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: k = cycles since the start was accepted (0 = idle, 1 = load, 2..N+1 = steps, N+2 = done).
  int           k = 0;
  bit           m_ok = 1'b0;
  logic [N-1:0] m_op = '0;
  bit           m_wd = 1'b0;
  always @(negedge clock) begin : monitor
    logic [7:0] e;
    e = '0;
    if (k == 0) begin
      e[7] = 1'b1;
    end else if (k == 1) begin
      e[6] = 1'b1;
      e[3] = 1'b1;
    end else if (k <= N + 1) begin
      e[4] = 1'b1;
      e[5] = m_op[k-2];
      e[2] = m_wd ? 1'b1 : (k != N + 1);
    end else begin
      e[1] = 1'b1;
      e[0] = m_wd;
    end
    if (m_ok) begin
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL outputs: got %b, want %b (cycle %0d, phase %0d)", outs(), e, cyc, k);
      end
    end
    if (reset) begin
      k    = 0;
      m_ok = 1'b1;
    end else if (k == 0) begin
      if (bus.start_valid) begin
        k    = 1;
        m_op = mplier_in;
        m_wd = wd;
      end
    end else if (k <= N + 1) begin
      k++;
    end else if (bus.result_ready) begin
      k = 0;
    end
  end

  function automatic logic [7:0] basic_step(input int i);
    case (i)
      0, 1:    return 8'b0011_0100;
      2:       return 8'b0001_0100;
      default: return 8'b0011_0000;
    endcase
  endfunction

  // Multiplier 1011 from IDLE: LOAD, steps add=1,1,0,1 dec=1,1,1,0, then DONE with no error.
  task automatic basic_run(input string tag);
    @(posedge clock); #1;
    mplier_in = 4'b1011;
    wd = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    @(negedge clock);
    chk({tag, "_load"}, outs(), 8'b0100_1000);
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      chk({tag, "_step"}, outs(), basic_step(i));
    end
    @(negedge clock);
    chk({tag, "_done"}, outs(), 8'b0000_0010);
  endtask

  task automatic finish_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 4 * N; t++) begin
      @(negedge clock);
      if (bus.result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_result_seen"}, 32'(seen), 1);
    @(posedge clock); #1;
    bus.result_ready = 1'b1;
    @(posedge clock); #1;
    bus.result_ready = 1'b0;
  endtask

  task automatic do_txn(input logic [N-1:0] m, input bit wdog, input int stall, input int rst_at);
    bit got;
    @(posedge clock); #1;
    mplier_in = m;
    wd = wdog;
    bus.start_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (bus.start_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    chk("txn_accept", 32'(got), 1);
    @(posedge clock); #1;
    if (!got) begin
      bus.start_valid = 1'b0;
      return;
    end
    got = 1'b0;
    for (int off = 1; off < 3 * N; off++) begin
      if (off == rst_at) begin
        reset = 1'b1;
        bus.start_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        return;
      end
      @(negedge clock);
      if (bus.result_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clock); #1;
      bus.start_valid = 1'($urandom_range(0, 1));
    end
    chk("txn_done", 32'(got), 1);
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    repeat (stall) begin
      @(posedge clock); #1;
    end
    bus.result_ready = 1'b1;
    @(posedge clock); #1;
    bus.result_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int second;
    int presets;
    int steps;
    bit rv_seen;
    int r;
    bus.start_valid  = 1'b1;
    bus.result_ready = 1'b0;

    // Reset held with start_valid high: stays IDLE, LOAD only after release.
    repeat (2) begin
      @(negedge clock);
      chk("reset_idle", outs(), 8'b1000_0000);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_release_idle", outs(), 8'b1000_0000);
    @(negedge clock);
    chk("reset_first_load", outs(), 8'b0100_1000);
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    finish_done("reset_run");

    // Basic multiply then back-pressure in DONE.
    basic_run("basic");
    repeat (4) begin
      @(negedge clock);
      chk("stall_hold", outs(), 8'b0000_0010);
    end
    @(posedge clock); #1;
    bus.result_ready = 1'b1;
    @(negedge clock);
    chk("stall_release", outs(), 8'b0000_0010);
    @(posedge clock); #1;
    bus.result_ready = 1'b0;
    @(negedge clock);
    chk("back_to_idle", outs(), 8'b1000_0000);

    // start_valid held continuously: loads spaced N+3 apart, one preset each.
    @(posedge clock); #1;
    mplier_in = 4'b0110;
    bus.start_valid  = 1'b1;
    bus.result_ready = 1'b1;
    first = -1;
    second = -1;
    presets = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clock);
      if (bus.do_preset) presets++;
      if (bus.do_load) begin
        if (first < 0) first = cyc;
        else begin
          second = cyc;
          break;
        end
      end
    end
    chk("start_spacing", 32'(second - first), N + 3);
    chk("preset_count", 32'(presets), 2);
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    repeat (N + 2) @(posedge clock);
    #1;
    bus.result_ready = 1'b0;

    // Watchdog: counter never reports zero.
    @(posedge clock); #1;
    wd = 1'b1;
    mplier_in = 4'b1001;
    bus.start_valid = 1'b1;
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    @(negedge clock);
    chk("wd_load", outs(), 8'b0100_1000);
    steps = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clock);
      if (bus.result_valid) break;
      if (bus.do_shift) steps++;
    end
    chk("wd_steps", 32'(steps), 4);
    chk("wd_done", outs(), 8'b0000_0011);
    @(posedge clock); #1;
    bus.result_ready = 1'b1;
    @(posedge clock); #1;
    bus.result_ready = 1'b0;
    wd = 1'b0;
    basic_run("wd_next");
    finish_done("wd_next");

    // Reset during the second STEP cycle.
    @(posedge clock); #1;
    mplier_in = 4'b1011;
    bus.start_valid = 1'b1;
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_step2", outs(), 8'b0011_0100);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_idle", outs(), 8'b1000_0000);
    rv_seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      rv_seen = rv_seen | bus.result_valid;
    end
    chk("rst_no_result", 32'(rv_seen), 0);
    basic_run("after_rst");
    finish_done("after_rst");

    // Randomized transactions: operands, watchdog, stalls and reset injection.
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 9));
      do_txn(N'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)),
             (r == 0) ? int'($urandom_range(1, N + 2)) : 0);
    end
    repeat (3) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_control.md
Name: multiplier_control

Overview:
- Sequencer FSM for the shift-add multiplier.
- Drives `multiplier_counter` (`do_preset`/`do_decrement`) and consumes its `is_zero` flag.
- Issues load/add/shift strobes to the operand/accumulator datapath.
- Accepts a start request via a valid/ready handshake and presents completion via a valid/ready handshake.

Parameters:
- N, 4, datapath width in bits. One multiply = N add/shift steps. Must match the counter's N.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  requester has operands ready on the datapath inputs.
- start_ready  output  1  controller can accept a start (IDLE only).
- do_load  output  1  datapath loads operands and clears the accumulator this edge.
- do_add  output  1  datapath adds the multiplicand into the accumulator this edge.
- do_shift  output  1  datapath shifts the accumulator/multiplier right this edge.
- multiplier_lsb  input  1  current LSB of the multiplier register.
- do_preset  output  1  counter loads N-1 this edge.
- do_decrement  output  1  counter decrements this edge.
- is_zero  input  1  counter value == 0 (combinational from counter).
- result_valid  output  1  product is stable in the datapath.
- result_ready  input  1  consumer accepts the product.
- protocol_error  output  1  `is_zero` did not arrive within N steps; valid while `result_valid`=1.

Behaviour:
- States: IDLE, LOAD, STEP, DONE. Encoding is free. All outputs are decoded from state plus current inputs; no output registers.
- Reset (reset=1 at an edge): state=IDLE, step counter=0, error flag=0. Reset overrides all other inputs, including mid-STEP and mid-DONE.
- Output values after reset:
  - start_ready=1
  - do_load=0, do_add=0, do_shift=0
  - do_preset=0, do_decrement=0
  - result_valid=0, protocol_error=0
- IDLE:
  - start_ready=1.
  - start_valid=1 -> LOAD next cycle. Otherwise remain.
- LOAD (exactly one cycle):
  - do_load=1, do_preset=1, start_ready=0.
  - Clear step counter and error flag. -> STEP.
- STEP (one add/shift step per cycle):
  - do_shift=1, do_add=multiplier_lsb.
  - If is_zero=1: do_decrement=0 -> DONE.
  - Else: do_decrement=1, step counter +1.
  - If step counter reaches N while is_zero=0: set error flag -> DONE. This is a watchdog for a missing or mis-sized counter.
  - Normal run = exactly N STEP cycles, with counter values N-1 ... 0.
- DONE:
  - result_valid=1; protocol_error=error flag. All strobes are 0.
  - result_ready=1 -> IDLE next cycle. Otherwise hold indefinitely; outputs stay stable while stalled.
- Latency: start accepted at edge E. Then:
  - LOAD during cycle E+1.
  - STEP during cycles E+2 .. E+N+1.
  - result_valid first high in cycle E+N+2.
  - Minimum start-to-start throughput is N+3 cycles.
- start_valid is ignored outside IDLE. It is not queued; the requester must hold it until start_ready=1.
- do_preset and do_decrement are never asserted in the same cycle.
- do_load is never asserted together with do_add or do_shift.
- Step counter width: $clog2(N+1) bits; it never wraps.

Test Plan (N=4, counter instantiated alongside):
- Reset: hold reset 2 cycles with start_valid=1 -> start_ready=1, all strobes 0, result_valid=0. LOAD is entered only after reset deasserts.
- Basic multiply: pulse start at edge E with multiplier=4'b1011 -> do_load at E+1. Then at E+2..E+5: do_shift=1 each cycle, do_add=1,1,0,1, do_decrement=1,1,1,0. result_valid=1 at E+6, protocol_error=0.
- Result back-pressure: result_ready=0 for 5 cycles in DONE -> result_valid stays 1, no strobes. result_ready=1 -> IDLE and start_ready=1 the next cycle.
- Start ignored while busy: start_valid=1 held continuously -> second LOAD occurs exactly N+3 cycles after the first; no extra do_preset during STEP or DONE.
- Watchdog: tie is_zero=0 -> exactly 4 STEP cycles, then DONE with result_valid=1, protocol_error=1. The next normal run reports protocol_error=0.
- Reset mid-operation: assert reset in the 2nd STEP cycle -> IDLE next cycle. No result_valid is produced. A new start then completes normally with the Basic multiply timing.
